mem_bus_arbiter: RTL and testbench

- Shares the single-port main memory between instruction fetch (IF), data access (MEM) and the DMA engine.
- Fixed-priority arbitration with an aging override so DMA cannot starve.
- DMA wins the bus for a whole non-preemptable burst of BURST_LEN writes.
- Sits between the pipelined CPU's two memory ports, the DMA device and the memory model, which has variable latency and a request/ack handshake.

---
 rtl/mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_bus_arbiter                                          |
// | Description : Shares one single-port memory between instruction fetch, |
// |               data access and a DMA burst engine. Fixed priority       |
// |               MEM > IF > DMA, with an aging override that forces a     |
// |               DMA grant after MAX_WAIT lost arbitrations.              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mem_bus_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int BURST_LEN = 4,
    parameter int MAX_WAIT  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    // instruction fetch port
    input  logic                         if_req,
    input  logic [WORD_SIZE-1:0]         if_addr,
    output logic [WORD_SIZE-1:0]         if_rdata,
    output logic                         if_ready,
    // data access port
    input  logic                         mem_req,
    input  logic                         mem_we,
    input  logic [WORD_SIZE-1:0]         mem_addr,
    input  logic [WORD_SIZE-1:0]         mem_wdata,
    output logic [WORD_SIZE-1:0]         mem_rdata,
    output logic                         mem_ready,
    // DMA burst port
    input  logic                         dma_req,
    input  logic [WORD_SIZE-1:0]         dma_addr,
    input  logic [WORD_SIZE-1:0]         dma_wdata,
    output logic [$clog2(BURST_LEN)-1:0] dma_idx,
    output logic                         dma_busy,
    output logic                         dma_done,
    // memory side
    output logic                         m_req,
    output logic                         m_we,
    output logic [WORD_SIZE-1:0]         m_addr,
    output logic [WORD_SIZE-1:0]         m_wdata,
    input  logic [WORD_SIZE-1:0]         m_rdata,
    input  logic                         m_ack
);

    localparam int c_IDX_W = $clog2(BURST_LEN);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_IF_ACC  = 2'd1;
    localparam logic [1:0] c_ST_MEM_ACC = 2'd2;
    localparam logic [1:0] c_ST_DMA_ACC = 2'd3;

    localparam logic [7:0]         c_WAIT_MAX = 8'(MAX_WAIT);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(BURST_LEN - 1);

    logic [1:0]           r_state,     w_state_nxt;
    logic [7:0]           r_wait_cnt,  w_wait_cnt_nxt;
    logic                 r_m_req,     w_m_req_nxt;
    logic                 r_m_we,      w_m_we_nxt;
    logic [WORD_SIZE-1:0] r_m_addr,    w_m_addr_nxt;
    logic [WORD_SIZE-1:0] r_m_wdata,   w_m_wdata_nxt;
    logic [WORD_SIZE-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic [WORD_SIZE-1:0] r_mem_rdata, w_mem_rdata_nxt;
    logic                 r_if_ready,  w_if_ready_nxt;
    logic                 r_mem_ready, w_mem_ready_nxt;
    logic                 r_dma_done,  w_dma_done_nxt;
    logic [c_IDX_W-1:0]   r_dma_idx,   w_dma_idx_nxt;

    logic [WORD_SIZE-1:0] w_dma_word_addr;
    logic [7:0]           w_wait_inc;
    logic                 w_force_dma;

    // Address of the current burst word; the add wraps modulo 2^WORD_SIZE.
    assign w_dma_word_addr = dma_addr + {{(WORD_SIZE-c_IDX_W){1'b0}}, r_dma_idx};
    assign w_wait_inc      = (r_wait_cnt == c_WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 8'd1;
    assign w_force_dma     = dma_req && (r_wait_cnt == c_WAIT_MAX);

    // Next-state and output computation for arbitration and access sequencing.
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_m_req_nxt     = r_m_req;
        w_m_we_nxt      = r_m_we;
        w_m_addr_nxt    = r_m_addr;
        w_m_wdata_nxt   = r_m_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_mem_rdata_nxt = r_mem_rdata;
        w_if_ready_nxt  = 1'b0;
        w_mem_ready_nxt = 1'b0;
        w_dma_done_nxt  = 1'b0;
        w_dma_idx_nxt   = r_dma_idx;

        case (r_state)
            c_ST_IDLE: begin
                if (w_force_dma || (!mem_req && !if_req && dma_req)) begin
                    // DMA grant: r_dma_idx is always 0 here, so this is the base.
                    w_state_nxt    = c_ST_DMA_ACC;
                    w_wait_cnt_nxt = 8'd0;
                    w_m_req_nxt    = 1'b1;
                    w_m_we_nxt     = 1'b1;
                    w_m_addr_nxt   = w_dma_word_addr;
                    w_m_wdata_nxt  = dma_wdata;
                end else if (mem_req) begin
                    w_state_nxt   = c_ST_MEM_ACC;
                    w_m_req_nxt   = 1'b1;
                    w_m_we_nxt    = mem_we;
                    w_m_addr_nxt  = mem_addr;
                    w_m_wdata_nxt = mem_wdata;
                    if (dma_req) begin
                        w_wait_cnt_nxt = w_wait_inc;
                    end
                end else if (if_req) begin
                    w_state_nxt   = c_ST_IF_ACC;
                    w_m_req_nxt   = 1'b1;
                    w_m_we_nxt    = 1'b0;
                    w_m_addr_nxt  = if_addr;
                    w_m_wdata_nxt = '0;
                    if (dma_req) begin
                        w_wait_cnt_nxt = w_wait_inc;
                    end
                end
            end

            c_ST_IF_ACC: begin
                if (m_ack) begin
                    w_state_nxt    = c_ST_IDLE;
                    w_m_req_nxt    = 1'b0;
                    w_if_rdata_nxt = m_rdata;
                    w_if_ready_nxt = 1'b1;
                end
            end

            c_ST_MEM_ACC: begin
                if (m_ack) begin
                    w_state_nxt     = c_ST_IDLE;
                    w_m_req_nxt     = 1'b0;
                    w_mem_ready_nxt = 1'b1;
                    // Writes leave the last read value visible on mem_rdata.
                    if (!r_m_we) begin
                        w_mem_rdata_nxt = m_rdata;
                    end
                end
            end

            c_ST_DMA_ACC: begin
                if (r_m_req) begin
                    if (m_ack) begin
                        w_m_req_nxt = 1'b0;
                        if (r_dma_idx == c_LAST_IDX) begin
                            w_dma_idx_nxt  = '0;
                            w_dma_done_nxt = 1'b1;
                            w_state_nxt    = c_ST_IDLE;
                        end else begin
                            w_dma_idx_nxt = r_dma_idx + 1'b1;
                        end
                    end
                end else begin
                    // One idle cycle between words, then start the next word.
                    w_m_req_nxt   = 1'b1;
                    w_m_we_nxt    = 1'b1;
                    w_m_addr_nxt  = w_dma_word_addr;
                    w_m_wdata_nxt = dma_wdata;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_m_req_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_wait_cnt  <= 8'd0;
            r_m_req     <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_dma_done  <= 1'b0;
            r_dma_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_m_req     <= w_m_req_nxt;
            r_m_we      <= w_m_we_nxt;
            r_m_addr    <= w_m_addr_nxt;
            r_m_wdata   <= w_m_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_mem_ready <= w_mem_ready_nxt;
            r_dma_done  <= w_dma_done_nxt;
            r_dma_idx   <= w_dma_idx_nxt;
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign mem_rdata = r_mem_rdata;
    assign mem_ready = r_mem_ready;
    assign dma_idx   = r_dma_idx;
    assign dma_busy  = (r_state == c_ST_DMA_ACC);
    assign dma_done  = r_dma_done;
    assign m_req     = r_m_req;
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_mem_bus_arbiter                                       |
// | Description : Directed self-checking bench for mem_bus_arbiter with a  |
// |               variable-latency memory model and scoreboard queues.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_mem_bus_arbiter;

    localparam int c_WS = 16;
    localparam int c_BL = 4;
    localparam int c_MW = 2;
    localparam int c_IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req;
    logic [c_WS-1:0] if_addr;
    logic [c_WS-1:0] if_rdata;
    logic            if_ready;
    logic            mem_req;
    logic            mem_we;
    logic [c_WS-1:0] mem_addr;
    logic [c_WS-1:0] mem_wdata;
    logic [c_WS-1:0] mem_rdata;
    logic            mem_ready;
    logic            dma_req;
    logic [c_WS-1:0] dma_addr;
    logic [c_WS-1:0] dma_wdata;
    logic [c_IW-1:0] dma_idx;
    logic            dma_busy;
    logic            dma_done;
    logic            m_req;
    logic            m_we;
    logic [c_WS-1:0] m_addr;
    logic [c_WS-1:0] m_wdata;
    logic [c_WS-1:0] m_rdata;
    logic            m_ack;

    logic [c_WS-1:0] dma_data_base;

    // Scoreboard: expected memory accesses {we, addr, wdata} and read results.
    logic [32:0]     acc_q[$];
    logic [15:0]     if_q[$];
    logic [15:0]     mem_q[$];
    logic [15:0]     mem_arr[logic [15:0]];

    int lat      = 1;
    int errors   = 0;
    int checks   = 0;
    int if_cnt   = 0;
    int mem_cnt  = 0;
    int done_cnt = 0;

    mem_bus_arbiter #(
        .WORD_SIZE (c_WS),
        .BURST_LEN (c_BL),
        .MAX_WAIT  (c_MW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_idx   (dma_idx),
        .dma_busy  (dma_busy),
        .dma_done  (dma_done),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack)
    );

    always #5 clk = ~clk;

    // DMA device supplies the selected burst word combinationally.
    assign dma_wdata = dma_data_base + {{(c_WS-c_IW){1'b0}}, dma_idx};

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until the selected DUT output is high at a negedge.
    task automatic wait_sig(input int which, input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            case (which)
                0:       seen = if_ready;
                1:       seen = mem_ready;
                2:       seen = dma_done;
                3:       seen = dma_busy;
                default: seen = m_req;
            endcase
        end
        if (!seen) check(tag, 96'(seen), 96'd1);
    endtask

    // Memory model: acks after 'lat' cycles of m_req, one-cycle ack pulse.
    initial begin : mem_model
        int          cnt;
        logic [32:0] exp_acc;
        cnt     = 0;
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                cnt   = 0;
                m_ack = 1'b0;
            end else if (m_ack) begin
                m_ack = 1'b0;
            end else if (m_req) begin
                cnt++;
                if (cnt >= lat) begin
                    cnt     = 0;
                    m_ack   = 1'b1;
                    exp_acc = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
                    check("mem_access", 96'({m_we, m_addr, (m_we ? m_wdata : 16'h0000)}), 96'(exp_acc));
                    if (m_we) mem_arr[m_addr] = m_wdata;
                    else      m_rdata = mem_arr.exists(m_addr) ? mem_arr[m_addr] : 16'h0000;
                end
            end
        end
    end

    // Response monitor: pops expected read data on each ready pulse.
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (if_ready | mem_ready | dma_done)
                check("pulse_onehot", 96'($countones({if_ready, mem_ready, dma_done})), 96'd1);
            if (if_ready) begin
                if_cnt++;
                e = (if_q.size() > 0) ? if_q.pop_front() : 'x;
                check("if_rdata", 96'(if_rdata), 96'(e));
            end
            if (mem_ready) begin
                mem_cnt++;
                e = (mem_q.size() > 0) ? mem_q.pop_front() : 'x;
                check("mem_rdata", 96'(mem_rdata), 96'(e));
            end
            if (dma_done) done_cnt++;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        dma_req = 1'b0; dma_addr = '0; dma_data_base = '0;
        mem_arr[16'h0010] = 16'hBEEF;
        mem_arr[16'h0030] = 16'h5A5A;
        mem_arr[16'h0040] = 16'h7777;
        mem_arr[16'h0050] = 16'h1111;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset then idle: every output stays zero.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_idle", 96'({if_rdata, mem_rdata, m_addr, m_wdata, m_we, m_req,
                                     dma_idx, dma_busy, dma_done, if_ready, mem_ready}), 96'd0);
        end

        // Reset during a MEM access: m_req drops, no mem_ready.
        lat = 10; mem_addr = 16'h0060; mem_we = 1'b0; mem_req = 1'b1;
        wait_sig(4, 5, "rst_grant_timeout");
        mem_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rst_drops_m_req", 96'({m_req, m_addr}), 96'd0);
        reset = 1'b0;
        repeat (lat + 3) @(negedge clk);
        check("rst_no_mem_ready", 96'(mem_cnt), 96'd0);

        // Single fetch with 3-cycle memory latency.
        lat = 3; if_addr = 16'h0010; if_req = 1'b1;
        acc_q.push_back({1'b0, 16'h0010, 16'h0000});
        if_q.push_back(16'hBEEF);
        @(negedge clk);
        check("fetch_grant", 96'({m_req, m_we, m_addr}), 96'({1'b1, 1'b0, 16'h0010}));
        if_req = 1'b0;
        @(negedge clk);
        check("fetch_m_req_c2", 96'({m_req, if_ready}), 96'({1'b1, 1'b0}));
        @(negedge clk);
        check("fetch_m_req_c3", 96'({m_req, if_ready}), 96'({1'b1, 1'b0}));
        @(negedge clk);
        check("fetch_ready", 96'({m_req, if_ready}), 96'({1'b0, 1'b1}));
        @(negedge clk);
        check("fetch_ready_once", 96'(if_ready), 96'd0);

        // Simultaneous IF and MEM write: MEM wins, then IF.
        lat = 2;
        mem_we = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h1234; mem_req = 1'b1;
        if_addr = 16'h0030; if_req = 1'b1;
        acc_q.push_back({1'b1, 16'h0020, 16'h1234});
        acc_q.push_back({1'b0, 16'h0030, 16'h0000});
        mem_q.push_back(16'h0000);
        if_q.push_back(16'h5A5A);
        @(negedge clk);
        check("sim_mem_first", 96'({m_req, m_we, m_addr}), 96'({1'b1, 1'b1, 16'h0020}));
        wait_sig(1, 10, "sim_mem_ready_timeout");
        mem_req = 1'b0;
        #1 check("sim_if_pending", 96'(if_cnt), 96'd1);
        wait_sig(0, 10, "sim_if_ready_timeout");
        if_req = 1'b0;
        #1 check("sim_counts", 96'({mem_cnt, if_cnt}), 96'({32'd1, 32'd2}));

        // DMA burst with a MEM read raised mid-burst.
        lat = 2; dma_addr = 16'h01F4; dma_data_base = 16'h00A0; dma_req = 1'b1;
        for (int i = 0; i < c_BL; i++)
            acc_q.push_back({1'b1, 16'(16'h01F4 + i), 16'(16'h00A0 + i)});
        wait_sig(3, 5, "dma_grant_timeout");
        dma_req = 1'b0;
        check("dma_first_word", 96'({dma_busy, m_req, m_we, m_addr, m_wdata}),
              96'({1'b1, 1'b1, 1'b1, 16'h01F4, 16'h00A0}));
        repeat (2) @(negedge clk);
        mem_we = 1'b0; mem_addr = 16'h0040; mem_req = 1'b1;
        acc_q.push_back({1'b0, 16'h0040, 16'h0000});
        mem_q.push_back(16'h7777);
        wait_sig(2, 40, "dma_done_timeout");
        check("dma_done_state", 96'({dma_busy, m_req, dma_idx}), 96'd0);
        @(negedge clk);
        check("mem_after_dma", 96'({m_req, m_we, m_addr, dma_done}), 96'({1'b1, 1'b0, 16'h0040, 1'b0}));
        wait_sig(1, 10, "dma_mem_ready_timeout");
        mem_req = 1'b0;

        // Starvation: IF and DMA held, IF wins twice, then DMA is forced.
        lat = 1; if_addr = 16'h0050; if_req = 1'b1;
        dma_addr = 16'h0300; dma_data_base = 16'h00C0; dma_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            acc_q.push_back({1'b0, 16'h0050, 16'h0000});
            if_q.push_back(16'h1111);
        end
        for (int i = 0; i < c_BL; i++)
            acc_q.push_back({1'b1, 16'(16'h0300 + i), 16'(16'h00C0 + i)});
        wait_sig(3, 30, "starve_dma_timeout");
        dma_req = 1'b0;
        #1 check("starve_if_wins", 96'(if_cnt), 96'd4);
        check("starve_wait_clr", 96'(dut.r_wait_cnt), 96'd0);
        wait_sig(2, 40, "starve_done_timeout");
        if_req = 1'b0;

        // Address wrap across the top of the address space.
        dma_addr = 16'hFFFE; dma_data_base = 16'h0010; dma_req = 1'b1;
        for (int i = 0; i < c_BL; i++)
            acc_q.push_back({1'b1, 16'(16'hFFFE + i), 16'(16'h0010 + i)});
        wait_sig(3, 5, "wrap_grant_timeout");
        dma_req = 1'b0;
        wait_sig(2, 40, "wrap_done_timeout");

        repeat (5) @(negedge clk);
        #1;
        check("queues_empty", 96'({acc_q.size(), if_q.size(), mem_q.size()}), 96'd0);
        check("pulse_totals", 96'({if_cnt, mem_cnt, done_cnt}), 96'({32'd4, 32'd2, 32'd3}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
